// File: rtl/exec_arbiter.sv
// exec_arbiter: round-robin two-requester issue into a fixed-latency execute unit.
// It routes each writeback to the requester that issued it, using owner tags.
// Define EXEC_ARB_PERF_EN to add the perf_clr/perf_cnt0/perf_cnt1 accept counters.
module exec_arbiter #(
  parameter int LAT = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        flush,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_data1,
  input  logic [31:0] req0_data2,
  input  logic [2:0]  req0_alu_op,
  input  logic [4:0]  req0_shift,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_data1,
  input  logic [31:0] req1_data2,
  input  logic [2:0]  req1_alu_op,
  input  logic [4:0]  req1_shift,
  output logic        ex_en,
  output logic [31:0] ex_data1,
  output logic [31:0] ex_data2,
  output logic [2:0]  ex_alu_op,
  output logic [4:0]  ex_shift,
  input  logic        ex_wb_en,
  input  logic [31:0] ex_dout,
  input  logic [3:0]  ex_cr,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [31:0] rsp_dout,
  output logic [3:0]  rsp_cr,
  output logic        busy
`ifdef EXEC_ARB_PERF_EN
  ,
  input  logic        perf_clr,
  output logic [15:0] perf_cnt0,
  output logic [15:0] perf_cnt1
`endif
);
  logic last, sel, acc, itag;
  logic [LAT-1:0] live, own;
  // grant: lone requester wins outright, contention goes to the one not served last
  assign sel = req1_valid & (~req0_valid | ~last);
  assign req0_ready = req0_valid & ~sel & ~flush;
  assign req1_ready = req1_valid & sel & ~flush;
  assign acc = req0_ready | req1_ready;
  assign rsp0_valid = ex_wb_en & live[LAT-1] & ~own[LAT-1];
  assign rsp1_valid = ex_wb_en & live[LAT-1] & own[LAT-1];
  assign rsp_dout = ex_dout;
  assign rsp_cr = ex_cr;
  assign busy = ex_en | (|live);
  // issue register: latch the winner's operands and owner, hold them when idle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last <= 1'b1;
      itag <= 1'b0;
      ex_en <= 1'b0;
      ex_data1 <= '0;
      ex_data2 <= '0;
      ex_alu_op <= '0;
      ex_shift <= '0;
    end else begin
      ex_en <= acc;
      if (acc) begin
        last <= sel;
        itag <= sel;
        ex_data1 <= sel ? req1_data1 : req0_data1;
        ex_data2 <= sel ? req1_data2 : req0_data2;
        ex_alu_op <= sel ? req1_alu_op : req0_alu_op;
        ex_shift <= sel ? req1_shift : req0_shift;
      end
    end
  end
  // tag pipe: shadows the execute latency; flush kills every entry including the one entering
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      live <= '0;
      own <= '0;
    end else begin
      live <= flush ? '0 : LAT'({live, ex_en});
      own <= LAT'({own, itag});
    end
  end
`ifdef EXEC_ARB_PERF_EN
  // saturating per-requester accept counters; clear beats increment
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_cnt0 <= '0;
      perf_cnt1 <= '0;
    end else begin
      perf_cnt0 <= perf_clr ? '0 : perf_cnt0 + 16'(req0_ready & ~&perf_cnt0);
      perf_cnt1 <= perf_clr ? '0 : perf_cnt1 + 16'(req1_ready & ~&perf_cnt1);
    end
  end
`endif
endmodule

// File: tb/tb_exec_arbiter.sv
// tb_exec_arbiter: randomized and directed checks of exec_arbiter against a transaction-level model.
module tb_exec_arbiter;
  localparam int LAT = 2;
  logic clk = 0, rstn = 0, flush = 0;
  logic req0_valid = 0, req1_valid = 0;
  logic [31:0] req0_data1 = 0, req0_data2 = 0, req1_data1 = 0, req1_data2 = 0;
  logic [2:0] req0_alu_op = 0, req1_alu_op = 0;
  logic [4:0] req0_shift = 0, req1_shift = 0;
  logic req0_ready, req1_ready, ex_en, rsp0_valid, rsp1_valid, busy;
  logic [31:0] ex_data1, ex_data2, rsp_dout;
  logic [2:0] ex_alu_op;
  logic [4:0] ex_shift;
  logic [3:0] rsp_cr;
`ifdef EXEC_ARB_PERF_EN
  logic perf_clr = 0;
  logic [15:0] perf_cnt0, perf_cnt1;
  logic [15:0] pc0, pc1;
`endif
  logic [LAT-1:0] wbp = '0;
  logic [31:0] dp [LAT] = '{default: 0};
  logic [3:0] cp [LAT] = '{default: 0};
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  exec_arbiter #(.LAT(LAT)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data1(req0_data1),
    .req0_data2(req0_data2), .req0_alu_op(req0_alu_op), .req0_shift(req0_shift),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data1(req1_data1),
    .req1_data2(req1_data2), .req1_alu_op(req1_alu_op), .req1_shift(req1_shift),
    .ex_en(ex_en), .ex_data1(ex_data1), .ex_data2(ex_data2), .ex_alu_op(ex_alu_op),
    .ex_shift(ex_shift), .ex_wb_en(wbp[LAT-1]), .ex_dout(dp[LAT-1]), .ex_cr(cp[LAT-1]),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_dout(rsp_dout),
    .rsp_cr(rsp_cr), .busy(busy)
`ifdef EXEC_ARB_PERF_EN
    , .perf_clr(perf_clr), .perf_cnt0(perf_cnt0), .perf_cnt1(perf_cnt1)
`endif
  );

  function automatic logic [31:0] alu(logic [2:0] op, logic [31:0] a, logic [31:0] b, logic [4:0] sh);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a << sh;
      3'd6: return a >> sh;
      default: return b;
    endcase
  endfunction

  function automatic logic [3:0] crf(logic [31:0] r);
    return {r[31], !r[31] && r != 0, r == 0, 1'b0};
  endfunction

  // stand-in execute unit: fixed LAT-cycle pipe, never reset, so killed ops still pulse writeback
  always @(posedge clk) begin
    wbp <= LAT'({wbp, ex_en});
    dp[0] <= alu(ex_alu_op, ex_data1, ex_data2, ex_shift);
    cp[0] <= crf(alu(ex_alu_op, ex_data1, ex_data2, ex_shift));
    for (int i = 1; i < LAT; i++) begin
      dp[i] <= dp[i-1];
      cp[i] <= cp[i-1];
    end
  end

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", n, act, exp, $time);
    end
  endtask

  // transaction-level model: each accepted op is a record with issue and writeback cycle numbers
  typedef struct {
    bit owner;
    bit live;
    int issue;
    int due;
    logic [31:0] d1, d2;
    logic [2:0] op;
    logic [4:0] sh;
  } rec_t;
  rec_t q[$];
  rec_t nr;
  int cyc = 0;
  bit m_last;
  logic [31:0] m_d1, m_d2;
  logic [2:0] m_op;
  logic [4:0] m_sh;
  bit ms, macc;

  function automatic bit winner(bit v0, bit v1, bit lst);
    if (v0 && v1) return !lst;
    return v1;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q.delete();
      m_last = 1;
      m_d1 = 0; m_d2 = 0; m_op = 0; m_sh = 0;
`ifdef EXEC_ARB_PERF_EN
      pc0 = 0; pc1 = 0;
`endif
    end else begin
      ms = winner(req0_valid, req1_valid, m_last);
      macc = !flush && (ms ? req1_valid : req0_valid);
      if (flush) foreach (q[i]) q[i].live = 0;
`ifdef EXEC_ARB_PERF_EN
      if (perf_clr) begin pc0 = 0; pc1 = 0; end
      else if (macc && !ms && pc0 != 16'hFFFF) pc0++;
      else if (macc && ms && pc1 != 16'hFFFF) pc1++;
`endif
      if (macc) begin
        nr.owner = ms; nr.live = 1; nr.issue = cyc + 1; nr.due = cyc + 1 + LAT;
        nr.d1 = ms ? req1_data1 : req0_data1;
        nr.d2 = ms ? req1_data2 : req0_data2;
        nr.op = ms ? req1_alu_op : req0_alu_op;
        nr.sh = ms ? req1_shift : req0_shift;
        q.push_back(nr);
        m_last = ms;
      end
      cyc++;
      foreach (q[i]) if (q[i].issue == cyc) begin
        m_d1 = q[i].d1; m_d2 = q[i].d2; m_op = q[i].op; m_sh = q[i].sh;
      end
      while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
    end
  end

  bit e_s, e_en, e_busy, e_v0, e_v1;
  logic [31:0] e_dout;
  logic [3:0] e_cr;
  always @(negedge clk) if (rstn) begin
    e_s = winner(req0_valid, req1_valid, m_last);
    e_en = 0; e_busy = 0; e_v0 = 0; e_v1 = 0; e_dout = 0; e_cr = 0;
    foreach (q[i]) begin
      if (q[i].issue == cyc) e_en = 1;
      if (q[i].issue == cyc || (q[i].live && q[i].issue < cyc && cyc <= q[i].due)) e_busy = 1;
      if (q[i].live && q[i].due == cyc) begin
        if (q[i].owner) e_v1 = 1; else e_v0 = 1;
        e_dout = alu(q[i].op, q[i].d1, q[i].d2, q[i].sh);
        e_cr = crf(e_dout);
      end
    end
    chk("req0_ready", req0_ready, !flush && req0_valid && !e_s);
    chk("req1_ready", req1_ready, !flush && req1_valid && e_s);
    chk("ex_en", ex_en, e_en);
    chk("ex_data1", ex_data1, m_d1);
    chk("ex_data2", ex_data2, m_d2);
    chk("ex_alu_op", ex_alu_op, m_op);
    chk("ex_shift", ex_shift, m_sh);
    chk("busy", busy, e_busy);
    chk("rsp0_valid", rsp0_valid, e_v0);
    chk("rsp1_valid", rsp1_valid, e_v1);
    chk("rsp_dout_pass", rsp_dout, dp[LAT-1]);
    if (e_v0 || e_v1) begin
      chk("rsp_dout", rsp_dout, e_dout);
      chk("rsp_cr", rsp_cr, e_cr);
    end
`ifdef EXEC_ARB_PERF_EN
    chk("perf_cnt0", perf_cnt0, pc0);
    chk("perf_cnt1", perf_cnt1, pc1);
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_ops();
    req0_data1 = $urandom; req0_data2 = $urandom; req0_alu_op = 3'($urandom); req0_shift = 5'($urandom);
    req1_data1 = $urandom; req1_data2 = $urandom; req1_alu_op = 3'($urandom); req1_shift = 5'($urandom);
  endtask

  initial begin
    repeat (3) step();
    @(negedge clk);
    chk("rst_ex_en", ex_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp0", rsp0_valid, 0);
    chk("rst_ex_data1", ex_data1, 0);
    step();
    rstn = 1;
    req0_valid = 1; req0_data1 = 5; req0_data2 = 3; req0_alu_op = 0; req0_shift = 0;
    @(negedge clk);
    chk("dir_ready0", req0_ready, 1);
    step();
    req0_valid = 0;
    @(negedge clk);
    chk("dir_ex_en", ex_en, 1);
    chk("dir_ex_data1", ex_data1, 5);
    repeat (LAT) @(posedge clk);
    @(negedge clk);
    chk("dir_rsp0", rsp0_valid, 1);
    chk("dir_dout", rsp_dout, 8);
    chk("dir_cr", rsp_cr, 4'b0100);
    step();
    req0_valid = 1; req1_valid = 1; rnd_ops();
    @(negedge clk);
    chk("rr_first_ready1", req1_ready, 1);
    chk("rr_first_ready0", req0_ready, 0);
    repeat (5) begin step(); rnd_ops(); end
    step();
    req1_valid = 0;
    @(negedge clk);
    chk("lone_ready0", req0_ready, 1);
    step();
    req0_valid = 0; req1_valid = 1; rnd_ops();
    @(negedge clk);
    chk("fl_issue_ready1", req1_ready, 1);
    step();
    flush = 1; req0_valid = 1; req1_valid = 1;
    @(negedge clk);
    chk("fl_ready0", req0_ready, 0);
    chk("fl_ready1", req1_ready, 0);
    chk("fl_ex_en", ex_en, 1);
    step();
    flush = 0; req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    chk("fl_busy", busy, 0);
    repeat (LAT - 1) @(posedge clk);
    @(negedge clk);
    chk("fl_wb_pulse", wbp[LAT-1], 1);
    chk("fl_rsp1", rsp1_valid, 0);
    repeat (1500) begin
      step();
      req0_valid = ($urandom % 4) != 0;
      req1_valid = ($urandom % 3) != 0;
      flush = ($urandom % 16) == 0;
      rnd_ops();
    end
    step();
    flush = 0; req0_valid = 1; req1_valid = 1; rnd_ops();
    step();
    rnd_ops();
    @(posedge clk);
    #2;
    rstn = 0; req0_valid = 0; req1_valid = 0;
    #1;
    chk("arst_ex_en", ex_en, 0);
    chk("arst_ex_data1", ex_data1, 0);
    chk("arst_busy", busy, 0);
    chk("arst_rsp0", rsp0_valid, 0);
    chk("arst_rsp1", rsp1_valid, 0);
    chk("arst_ready0", req0_ready, 0);
    #1;
    rstn = 1;
    for (int i = 0; i <= LAT; i++) begin
      @(negedge clk);
      chk("arst_no_rsp0", rsp0_valid, 0);
      chk("arst_no_rsp1", rsp1_valid, 0);
    end
    step();
    req0_valid = 1; req1_valid = 1;
    @(negedge clk);
    chk("arst_first_ready0", req0_ready, 1);
    chk("arst_first_ready1", req1_ready, 0);
`ifdef EXEC_ARB_PERF_EN
    step();
    req0_valid = 0; req1_valid = 0; perf_clr = 1;
    step();
    perf_clr = 0; req0_valid = 1;
    repeat (65534) step();
    @(negedge clk);
    chk("perf_fffe", perf_cnt0, 16'hFFFE);
    repeat (3) step();
    @(negedge clk);
    chk("perf_sat", perf_cnt0, 16'hFFFF);
    perf_clr = 1;
    step();
    perf_clr = 0; req0_valid = 0;
    @(negedge clk);
    chk("perf_clr", perf_cnt0, 0);
`endif
    step();
    req0_valid = 0; req1_valid = 0;
    repeat (LAT + 3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
